mem_port_arbiter: RTL and testbench

Shares one single-ported instruction/data memory between the pipeline's IF stage (fetch) and MEM stage (LW/SW). The arbiter grants MEM-stage data accesses priority over fetches and sequences each access through a request/acknowledge handshake with the memory. It produces the stall used to freeze the pipeline, lets a taken branch squash an in-flight fetch, and aborts accesses that are never acknowledged.

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the IF stage
// (instruction fetch) and the MEM stage (loads/stores). Data accesses win
// over fetches; each access runs a request/acknowledge handshake with the
// memory, guarded by a watchdog that aborts accesses never acknowledged.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   if_req_i/if_addr_i/if_flush_i   fetch request, PC, branch squash pulse
//   if_ready_o/if_rdata_o           fetch completion pulse and instruction
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  data request (load/store)
//   d_ready_o/d_rdata_o             data completion pulse and load data
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o  memory access (registered)
//   mem_rdata_i/mem_ack_i           memory read data and completion
//   stall_o                         pipeline freeze (combinational)
//   err_o                           watchdog abort pulse
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WDOG   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ready_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam int unsigned     CNT_W    = 8;
    localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(WDOG);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                kill_q, kill_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_ready_q, if_ready_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                d_ready_q, d_ready_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                err_q, err_d;

    // A requester's req is ignored in its own ready cycle: it is still
    // showing the access that just completed.
    logic if_req_m, d_req_m;
    assign if_req_m = if_req_i & ~if_ready_q;
    assign d_req_m  = d_req_i  & ~d_ready_q;

    // A flush landing in the final cycle of a fetch must still suppress it.
    logic kill_eff;
    assign kill_eff = kill_q | ((state_q == IF_BUSY) & if_flush_i);

    // Ack in the limit cycle wins over the abort.
    logic timeout;
    assign timeout = ~mem_ack_i & (cnt_q == WDOG_LIM);

    logic [DATA_W-1:0] done_data;
    assign done_data = mem_ack_i ? mem_rdata_i : '0;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            kill_q      <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_ready_q   <= 1'b0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_ready_q   <= d_ready_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    // Grant, access sequencing, flush and watchdog.
    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_ready_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                cnt_d  = '0;
                if (d_req_m) begin
                    state_d     = D_BUSY;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we_i;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                end else if (if_req_m) begin
                    state_d    = IF_BUSY;
                    mem_en_d   = 1'b1;
                    mem_addr_d = if_addr_i;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (mem_ack_i || timeout) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                    err_d   = timeout;
                    if (state_q == IF_BUSY) begin
                        if (!kill_eff) begin
                            if_ready_d = 1'b1;
                            if_rdata_d = done_data;
                        end
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = done_data;
                    end
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    kill_d   = kill_eff;
                    mem_en_d = 1'b1;
                    mem_we_d = mem_we_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall_o     = (if_req_i & ~if_ready_q) | (d_req_i & ~d_ready_q);
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_ready_o  = if_ready_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_ready_o   = d_ready_q;
    assign d_rdata_o   = d_rdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized concurrent fetch/data traffic; a negedge monitor holds the
// memory model and scores every ready pulse against queued expectations.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_flush = 1'b0;
    logic          if_ready_o;
    logic [DW-1:0] if_rdata_o;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready_o;
    logic [DW-1:0] d_rdata_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          stall_o;
    logic          err_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WDOG(WD)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_ready_o(d_ready_o), .d_rdata_o(d_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .stall_o(stall_o), .err_o(err_o)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        bit            err;
        bit            chk_rdata;
        int            delay;
    } rec_t;

    rec_t ifq[$];
    rec_t dq[$];
    int   checks = 0;
    int   failures = 0;

    logic [DW-1:0] mem     [bit [31:0]];
    logic [DW-1:0] exp_mem [bit [31:0]];
    int            delay_map [bit [31:0]];
    bit            if_addr_set [bit [31:0]];

    bit            cur_d_valid = 1'b0;
    bit            cur_d_we = 1'b0;
    logic [AW-1:0] cur_d_addr = '0;
    logic [DW-1:0] cur_d_wdata = '0;

    int cyc = 0;
    int if_done_cyc = 0, d_done_cyc = 0;
    int if_rdy_cnt = 0, d_rdy_cnt = 0, err_cnt = 0;
    bit spurious_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] fval(input bit [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [DW-1:0] exp_read(input bit [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : fval(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor + memory model: score ready pulses, then drive the memory side.
    int            m_cnt = 0;
    int            m_delay = 0;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_we;
    rec_t          mr;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_cnt   = 0;
            mem_ack = 1'b0;
        end else begin
            check("stall", 32'(stall_o), 32'((if_req & ~if_ready_o) | (d_req & ~d_ready_o)));
            if (err_o) begin
                err_cnt++;
                check("err_has_owner", 32'(if_ready_o | d_ready_o), 32'd1);
            end
            if (if_ready_o) begin
                if_rdy_cnt++;
                if (ifq.size() == 0) fail_now("unexpected_if_ready");
                else begin
                    mr = ifq.pop_front();
                    check("if_rdata", if_rdata_o, mr.rdata);
                    check("if_err", 32'(err_o), 32'(mr.err));
                    check("if_len", m_cnt, ((mr.delay > WD) ? WD : mr.delay) + 1);
                end
            end
            if (d_ready_o) begin
                d_rdy_cnt++;
                if (dq.size() == 0) fail_now("unexpected_d_ready");
                else begin
                    mr = dq.pop_front();
                    if (mr.chk_rdata) check("d_rdata", d_rdata_o, mr.rdata);
                    check("d_err", 32'(err_o), 32'(mr.err));
                    check("d_len", m_cnt, ((mr.delay > WD) ? WD : mr.delay) + 1);
                end
            end
            if (mem_en_o) begin
                if (m_cnt == 0) begin
                    m_addr  = mem_addr_o;
                    m_wdata = mem_wdata_o;
                    m_we    = mem_we_o;
                    m_delay = delay_map.exists(mem_addr_o) ? delay_map[mem_addr_o] : 1000;
                    if (cur_d_valid && mem_addr_o == cur_d_addr) begin
                        check("mem_we_data", 32'(mem_we_o), 32'(cur_d_we));
                        if (cur_d_we) check("mem_wdata", mem_wdata_o, cur_d_wdata);
                    end else if (if_addr_set.exists(mem_addr_o)) begin
                        check("mem_we_fetch", 32'(mem_we_o), 32'd0);
                    end else begin
                        fail_now("mem_access_unknown_addr");
                    end
                end else begin
                    check("mem_addr_stable", mem_addr_o, m_addr);
                    check("mem_we_stable", 32'(mem_we_o), 32'(m_we));
                    check("mem_wdata_stable", mem_wdata_o, m_wdata);
                end
                if (m_cnt == m_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
                    mem_rdata = mem.exists(mem_addr_o) ? mem[mem_addr_o] : fval(mem_addr_o);
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                m_cnt++;
            end else begin
                m_cnt     = 0;
                mem_ack   = spurious_ack ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    task automatic if_txn(input logic [AW-1:0] a, input int dly, input int flush_at);
        rec_t r;
        int   k;
        delay_map[a]   = dly;
        if_addr_set[a] = 1'b1;
        r.delay     = dly;
        r.err       = (dly > WD);
        r.rdata     = r.err ? '0 : exp_read(a);
        r.chk_rdata = 1'b1;
        ifq.push_back(r);
        if_addr = a;
        if_req  = 1'b1;
        k = 0;
        forever begin
            tick();
            if (if_ready_o) begin
                if_done_cyc = cyc;
                break;
            end
            if (k == flush_at) begin
                if_flush = 1'b1;
                if_req   = 1'b0;
                r = ifq.pop_back();
                tick();
                if_flush = 1'b0;
                break;
            end
            k++;
            if (k > 300) begin
                fail_now("if_ready_timeout");
                break;
            end
        end
        if_req = 1'b0;
    endtask

    task automatic d_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int dly, input bit scramble);
        rec_t r;
        int   k;
        delay_map[a] = dly;
        cur_d_valid  = 1'b1;
        cur_d_we     = we;
        cur_d_addr   = a;
        cur_d_wdata  = wd;
        r.delay     = dly;
        r.err       = (dly > WD);
        r.rdata     = r.err ? '0 : exp_read(a);
        r.chk_rdata = !we || r.err;
        dq.push_back(r);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        k = 0;
        forever begin
            tick();
            if (d_ready_o) begin
                d_done_cyc = cyc;
                break;
            end
            // Once the access is underway the store data must already be latched.
            if (scramble && mem_en_o && mem_addr_o == a) d_wdata = $urandom;
            k++;
            if (k > 300) begin
                fail_now("d_ready_timeout");
                break;
            end
        end
        if (we && dly <= WD) exp_mem[a] = wd;
        d_req       = 1'b0;
        cur_d_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n_if, n_err;
        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_en", 32'(mem_en_o), 32'd0);
        check("rst_mem_we", 32'(mem_we_o), 32'd0);
        check("rst_if_ready", 32'(if_ready_o), 32'd0);
        check("rst_d_ready", 32'(d_ready_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 32'd0);
        check("rst_if_rdata", if_rdata_o, 32'd0);
        check("rst_d_rdata", d_rdata_o, 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Fetch only.
        mem[32'h40]     = 32'h2008_0005;
        exp_mem[32'h40] = 32'h2008_0005;
        if_txn(32'h40, 2, -1);
        check("fetch_rdata_direct", if_rdata_o, 32'h2008_0005);
        repeat (2) tick();

        // Collision: data first, fetch granted in the d_ready cycle.
        fork
            if_txn(32'h44, 1, -1);
            d_txn(1'b0, 32'h100, 32'h0, 2, 1'b0);
        join
        check("collision_gap", if_done_cyc - d_done_cyc, 32'd3);
        repeat (2) tick();

        // Store with store data changing mid-access, then read it back.
        d_txn(1'b1, 32'h200, 32'hDEAD_BEEF, 3, 1'b1);
        d_txn(1'b0, 32'h200, 32'h0, 0, 1'b0);
        check("store_readback", d_rdata_o, 32'hDEAD_BEEF);
        repeat (2) tick();

        // Flush during a fetch, then a fetch at a new PC.
        n_if = if_rdy_cnt;
        if_txn(32'h80, 4, 1);
        if_txn(32'h84, 1, -1);
        repeat (6) tick();
        check("flush_ready_count", if_rdy_cnt - n_if, 32'd1);

        // Watchdog: abort, then ack exactly at the limit.
        n_err = err_cnt;
        d_txn(1'b0, 32'h300, 32'h0, 255, 1'b0);
        d_txn(1'b0, 32'h304, 32'h0, WD, 1'b0);
        repeat (2) tick();
        check("wdog_err_count", err_cnt - n_err, 32'd1);

        // Randomized concurrent traffic.
        spurious_ack = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int fl;
                    repeat ($urandom_range(0, 3)) tick();
                    fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
                    if_txn(32'h1000 + 32'(4 * i), int'($urandom_range(0, WD)), fl);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    int r, dly;
                    repeat ($urandom_range(0, 3)) tick();
                    r   = int'($urandom_range(0, 9));
                    dly = (r < 7) ? int'($urandom_range(0, 3)) : (r == 7) ? WD : (r == 8) ? WD + 1 : 255;
                    d_txn(1'($urandom_range(0, 1)), 32'h8_0000 + 32'(4 * $urandom_range(0, 7)),
                          $urandom, dly, 1'($urandom_range(0, 1)));
                end
            end
        join
        spurious_ack = 1'b0;
        repeat (4) tick();

        // Reset in the middle of a data access.
        begin
            int k;
            int n_d;
            n_d = d_rdy_cnt;
            n_if = if_rdy_cnt;
            delay_map[32'h400] = 255;
            cur_d_valid = 1'b1;
            cur_d_we    = 1'b0;
            cur_d_addr  = 32'h400;
            d_we   = 1'b0;
            d_addr = 32'h400;
            d_req  = 1'b1;
            for (k = 0; k < 20; k++) begin
                tick();
                if (mem_en_o) break;
            end
            check("rstmid_access_started", 32'(mem_en_o), 32'd1);
            tick();
            #2;
            rst_n = 1'b0;
            #1;
            check("rstmid_mem_en", 32'(mem_en_o), 32'd0);
            check("rstmid_mem_addr", mem_addr_o, 32'd0);
            check("rstmid_d_ready", 32'(d_ready_o), 32'd0);
            check("rstmid_d_rdata", d_rdata_o, 32'd0);
            check("rstmid_if_rdata", if_rdata_o, 32'd0);
            check("rstmid_err", 32'(err_o), 32'd0);
            check("rstmid_stall", 32'(stall_o), 32'd1);
            d_req = 1'b0;
            cur_d_valid = 1'b0;
            tick();
            rst_n = 1'b1;
            repeat (8) tick();
            check("rstmid_no_d_ready", d_rdy_cnt - n_d, 32'd0);
            check("rstmid_no_if_ready", if_rdy_cnt - n_if, 32'd0);
        end

        check("ifq_drained", ifq.size(), 32'd0);
        check("dq_drained", dq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
